// File: rtl/hex_display_bank.sv
// rtl/hex_display_bank.sv - bank of active-low 7-segment digits with registered load, leading-zero blanking, blink and PWM dimming
module hex_display_bank #(
    parameter int DIGITS   = 5,
    parameter int TICK_DIV = 12_500_000,
    parameter int PWM_BITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [PWM_BITS-1:0]   bright,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  blink_phase
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [4*DIGITS-1:0] value_q;
    logic [TICK_W-1:0]   tick_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;
    logic [DIGITS-1:0]   upper_zero;
    logic [7*DIGITS-1:0] hex_next;

    // Font bits are {g,f,e,d,c,b,a}, 0 = segment lit
    function automatic logic [6:0] seg_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            value_q     <= '0;
            tick_cnt    <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
            HEX         <= '1;
        end else begin
            if (load) begin
                value_q <= value;
            end
            if (tick_cnt == TICK_LAST) begin
                tick_cnt    <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
            HEX     <= hex_next;
        end
    end

    assign pwm_on = (bright == '1) || (pwm_cnt < bright);

    // upper_zero[d]: nibbles d..DIGITS-1 are all zero
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            run           = run && (value_q[4*d +: 4] == 4'h0);
            upper_zero[d] = run;
        end
    end

    always_comb begin
        logic dark;
        hex_next = '1;
        for (int d = 0; d < DIGITS; d++) begin
            dark = (blink_mask[d] && blink_phase)
                || (blank_lz && (d > 0) && upper_zero[d])
                || !pwm_on;
            hex_next[7*d +: 7] = dark ? 7'h7F : seg_font(value_q[4*d +: 4]);
        end
    end

endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Parametrised successor to the per-digit hex decoders: drives a bank of `DIGITS` active-low 7-segment displays from one packed value. Adds registered load, leading-zero suppression, per-digit blink from an on-chip prescaler, and PWM brightness. Sits between board-level switch/status logic and the HEX pins in the top level, clocked from CLOCK_50.

## Interface
- `DIGITS`, 5, number of 7-segment digits driven (1..8).
- `TICK_DIV`, 12_500_000, clock cycles per blink half-period (≥2).
- `PWM_BITS`, 4, width of brightness control and PWM counter.

- `CLOCK_50` in 1: sole clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load` in 1: capture `value` this cycle.
- `value` in 4*DIGITS: nibble d at [4d+3:4d], digit 0 rightmost.
- `blank_lz` in 1: leading-zero suppression enable.
- `blink_mask` in DIGITS: bit d set makes digit d blink.
- `bright` in PWM_BITS: brightness, 0 = dark, all-ones = full on.
- `HEX` out 7*DIGITS: digit d segments a..g at [7d+0]..[7d+6], active-low (0 = lit).
- `blink_phase` out 1: current blink phase, 1 = blinking digits dark.

## Operation
- Value register `value_q`: loads `value` on a clock edge with `load`=1, else holds. Reset 0.
- Prescaler `tick_cnt`: counts 0..TICK_DIV-1 and wraps. On the wrap edge (count = TICK_DIV-1), `blink_phase` toggles. Reset: count 0, phase 0.
- PWM counter `pwm_cnt`: PWM_BITS wide, free-running, wraps at 2^PWM_BITS. Reset 0.
  - `pwm_on` = (`bright` == all-ones) OR (`pwm_cnt` < `bright`), unsigned compare.
- Digit d decode: standard hex font 0-F, active-low, segment order a..g. Values: 0→7'b0000001 (bit g = 1, at [7d+6]), 8→all 0, F→a,e,f,g lit.
- Digit d forced dark (all 7 bits = 1) when any of these holds:
  - `blink_mask[d]` AND `blink_phase`.
  - `blank_lz` AND d > 0 AND nibbles d..DIGITS-1 of `value_q` are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
  - NOT `pwm_on`.
- `HEX` is a register fed by the decode/blank logic above. Reset value: all ones (every segment dark).

## Timing
- Load latency: `load` sampled at edge N updates `value_q` at N. `HEX` reflects the new value at edge N+1, so there are 2 edges from input to pin.
- `blank_lz`, `blink_mask` and `bright` changes are combinational into the `HEX` register: visible 1 edge later. No synchronisers are in the block; the caller syncs switch inputs.
- Blink period: 2*TICK_DIV cycles. First toggle to phase 1 at edge TICK_DIV after reset release.
- PWM period: 2^PWM_BITS cycles. For `bright` = b (not all-ones), segments lit b of every 2^PWM_BITS cycles.
- Simultaneous `load` and prescaler wrap on one edge: both take effect. The next `HEX` uses the new value and the new phase.
- `load` held high: `value_q` follows `value` every cycle.
- Reset asserted mid-operation: `HEX` goes all ones, `blink_phase` 0, and all counters and `value_q` clear, immediately and asynchronously. The first registered `HEX` update comes at the first edge after release.
- Counter widths are derived from `TICK_DIV` with $clog2. No overflow beyond TICK_DIV-1 is permitted.

## Test plan
Bench parameters: DIGITS=5, TICK_DIV=4, PWM_BITS=4, `bright`=4'hF unless stated.
- Reset/load: hold `reset`=0, then verify `HEX`=35'h7FFFFFFFF and `blink_phase`=0. Release, then `load`=1 with `value`=20'h1A3F0. Expect two edges later, digits 0..4 = 0000001, 0111000, 0000110, 0001000, 1001111 ([7d+0]→[7d+6]).
- Leading zeros: `value`=20'h00030, `blank_lz`=1. Expect digits 2..4 dark, digit 1 shows "3", digit 0 shows "0". With `value`=0, only digit 0 is lit. With `blank_lz`=0, all five show "0".
- Blink: `blink_mask`=5'b00100, `value`=20'h88888. Expect `blink_phase` toggling every 4 cycles. Digit 2 is all ones while phase=1 and all zeros while phase=0; other digits stay all zeros.
- PWM: `bright`=4'h4, `value`=20'h88888. Over 16 consecutive cycles, `HEX` is lit in exactly 4. With `bright`=0, it is never lit.
- Collision: assert `load` on the prescaler wrap edge with `blink_mask`=all ones. The next `HEX` shows the new value's blink-dark state according to the new phase.
- Async reset mid-blink: drop `reset` between edges. `HEX` goes all ones and `blink_phase` 0 before the next edge. After release, the first toggle comes after 4 cycles.
